// File: rtl/seg_pkg.sv
// seg_pkg: shared FSM encoding, anode constants and sizing helpers for the display scanner
package seg_pkg;
   typedef enum logic {S_BLANK, S_SHOW} state_t;
   localparam logic [7:0] AN_OFF = 8'hFF;
   function automatic logic [7:0] an_onecold(input logic [2:0] idx);
      return ~(8'b1 << idx);
   endfunction
   function automatic int clog2(input int v);
      int r = 1;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/scan_timer.sv
// scan_timer: interval down-counter; a zero count means the interval restarts from len
module scan_timer #(
   parameter int W = 4
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic [W-1:0] len,
   output logic [W-1:0] rem,
   output logic         done
);
   logic [W-1:0] cnt;
   // cycles left in the current interval, including this one
   always_comb begin
      rem  = cnt == '0 ? len : cnt;
      done = rem == W'(1);
   end
   // count down, returning to zero on the last cycle so the next interval reloads
   always_ff @(posedge CLK) cnt <= RST || done ? '0 : rem - W'(1);
endmodule

// File: rtl/seg_scan_scheduler.sv
// seg_scan_scheduler: multiplexes DIGITS nibbles onto a common-anode display with blanking and frame-aligned loads
module seg_scan_scheduler
   import seg_pkg::*;
#(
   parameter int DIGITS = 3,
   parameter int DWELL  = 1024,
   parameter int BLANK  = 16
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [4*DIGITS-1:0]   DIGIT_DATA,
   input  logic [DIGITS-1:0]     DIGIT_EN,
   input  logic                  LOAD,
   output logic                  LOAD_ACK,
   output logic [3:0]            NIBBLE,
   output logic [DIGITS-1:0]     AN,
   output logic [2:0]            CUR_DIGIT,
   output logic                  FRAME_TICK
);
   localparam int TMAX = DWELL > BLANK ? DWELL : BLANK;
   localparam int TW   = clog2(TMAX + 1);
   state_t state, state_n;
   logic [2:0] digit_n;
   logic show, show_n, done, frame_end_n;
   logic [TW-1:0] len, rem;
   logic [4*DIGITS-1:0] sh_data;
   logic [DIGITS-1:0] sh_en;
   logic [31:0] data32;
   logic [7:0] en8;
   logic [DIGITS-1:0] an_lit;
   assign show = state == S_SHOW || BLANK == 0;
   assign len  = show ? TW'(DWELL) : TW'(BLANK);
   scan_timer #(.W(TW)) u_timer (
      .CLK  (CLK),
      .RST  (RST),
      .len  (len),
      .rem  (rem),
      .done (done)
   );
   // next slot/state and a one-cycle lookahead of the frame-end cycle so outputs can stay registered
   always_comb begin
      digit_n     = done && show ? (CUR_DIGIT == 3'(DIGITS - 1) ? 3'd0 : CUR_DIGIT + 3'd1) : CUR_DIGIT;
      state_n     = !done ? state : (show && BLANK != 0) ? S_BLANK : S_SHOW;
      show_n      = state_n == S_SHOW || BLANK == 0;
      frame_end_n = show_n && digit_n == 3'(DIGITS - 1) && (done ? DWELL == 1 : 32'(rem) == 32'd2);
      data32      = 32'(sh_data);
      en8         = 8'(sh_en);
      an_lit      = DIGITS'(an_onecold(digit_n));
   end
   // scan FSM with registered outputs; the shadow only changes on the frame-end cycle
   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= S_BLANK;
         CUR_DIGIT  <= 3'd0;
         AN         <= DIGITS'(AN_OFF);
         NIBBLE     <= 4'd0;
         LOAD_ACK   <= 1'b0;
         FRAME_TICK <= 1'b0;
         sh_data    <= '0;
         sh_en      <= '0;
      end else begin
         state      <= state_n;
         CUR_DIGIT  <= digit_n;
         AN         <= show_n && en8[digit_n] ? an_lit : DIGITS'(AN_OFF);
         if (done && show) NIBBLE <= data32[{digit_n, 2'b00} +: 4];
         FRAME_TICK <= frame_end_n;
         LOAD_ACK   <= frame_end_n && LOAD;
         if (frame_end_n && LOAD) begin
            sh_data <= DIGIT_DATA;
            sh_en   <= DIGIT_EN;
         end
      end
   end
endmodule

// File: tb/tb_seg_scan_scheduler.sv
// tb_seg_scan_scheduler: randomized and directed scan/load checks against a frame-arithmetic reference model
module tb_seg_scan_scheduler;
   localparam int D = 3;
   logic CLK = 1'b0, RST = 1'b1, LOAD = 1'b0;
   logic [11:0] DIGIT_DATA = '0;
   logic [2:0] DIGIT_EN = '0;
   logic ack_a, tick_a, ack_b, tick_b;
   logic [3:0] nib_a, nib_b;
   logic [2:0] an_a, an_b, cd_a, cd_b;
   int checks = 0, failures = 0;
   int bl[2] = '{2, 0};
   int dw[2] = '{4, 1};
   int n[2];
   logic [11:0] cur_d[2], nxt_d[2];
   logic [2:0] cur_e[2], nxt_e[2];
   logic armed = 1'b0;
   int acks_a = 0;
   int at, a0;
   always #5 CLK = ~CLK;
   seg_scan_scheduler #(.DIGITS(3), .DWELL(4), .BLANK(2)) u_a (
      .CLK(CLK), .RST(RST), .DIGIT_DATA(DIGIT_DATA), .DIGIT_EN(DIGIT_EN), .LOAD(LOAD),
      .LOAD_ACK(ack_a), .NIBBLE(nib_a), .AN(an_a), .CUR_DIGIT(cd_a), .FRAME_TICK(tick_a)
   );
   seg_scan_scheduler #(.DIGITS(3), .DWELL(1), .BLANK(0)) u_b (
      .CLK(CLK), .RST(RST), .DIGIT_DATA(DIGIT_DATA), .DIGIT_EN(DIGIT_EN), .LOAD(LOAD),
      .LOAD_ACK(ack_b), .NIBBLE(nib_b), .AN(an_b), .CUR_DIGIT(cd_b), .FRAME_TICK(tick_b)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic cycle();
      logic p_rst, p_load, tk;
      logic [11:0] p_data;
      logic [2:0] p_en, an_e;
      logic [3:0] nib_e;
      int s, f, p, slot, off;
      string t;
      p_rst = RST;
      p_load = LOAD;
      p_data = DIGIT_DATA;
      p_en = DIGIT_EN;
      @(posedge CLK);
      #1;
      if (p_rst) armed = 1'b1;
      if (!armed) return;
      for (int k = 0; k < 2; k++) begin
         t = k == 0 ? "a" : "b";
         s = bl[k] + dw[k];
         f = D * s;
         if (p_rst) begin
            n[k] = 0;
            cur_d[k] = '0; cur_e[k] = '0; nxt_d[k] = '0; nxt_e[k] = '0;
         end else n[k]++;
         p = n[k] % f;
         slot = p / s;
         off = p % s;
         if (p == 0) begin
            cur_d[k] = nxt_d[k];
            cur_e[k] = nxt_e[k];
         end
         tk = p == f - 1;
         if (tk && p_load) begin
            nxt_d[k] = p_data;
            nxt_e[k] = p_en;
         end
         an_e = (off >= bl[k] && cur_e[k][slot]) ? 3'(~(1 << slot)) : 3'b111;
         nib_e = 4'((cur_d[k] >> (4 * slot)) & 12'hF);
         chk({"an_", t}, k == 0 ? an_a : an_b, an_e);
         chk({"nibble_", t}, k == 0 ? nib_a : nib_b, nib_e);
         chk({"cur_digit_", t}, k == 0 ? cd_a : cd_b, slot);
         chk({"frame_tick_", t}, k == 0 ? tick_a : tick_b, tk);
         chk({"load_ack_", t}, k == 0 ? ack_a : ack_b, tk && p_load);
      end
      if (ack_a) acks_a++;
   endtask
   task automatic run(input int c);
      repeat (c) cycle();
   endtask
   task automatic wait_p(input int target);
      for (int i = 0; i < 40 && n[0] % 18 != target; i++) cycle();
      chk("wait_phase", n[0] % 18, target);
   endtask
   task automatic wait_ack(output int ph);
      ph = -1;
      for (int i = 0; i < 60 && ph < 0; i++) begin
         cycle();
         if (ack_a) ph = n[0] % 18;
      end
      LOAD = 1'b0;
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog checks=%0d", checks);
      $fatal(1);
   end
   initial begin
      cycle();
      cycle();
      RST = 1'b0;
      chk("rst_an", an_a, 3'b111);
      chk("rst_cur_digit", cd_a, 0);
      chk("rst_nibble", nib_a, 0);
      DIGIT_DATA = 12'h3A7; DIGIT_EN = 3'b111; LOAD = 1'b1;
      wait_ack(at);
      chk("s1_ack_cycle", n[0], 17);
      run(18);
      DIGIT_DATA = 12'h5C1; DIGIT_EN = 3'b101; LOAD = 1'b1;
      wait_ack(at);
      chk("s2_ack_phase", at, 17);
      run(18);
      wait_p(5);
      DIGIT_DATA = 12'h111; DIGIT_EN = 3'b111; LOAD = 1'b1;
      run(5);
      DIGIT_DATA = 12'h9E4;
      wait_ack(at);
      chk("s3_ack_phase", at, 17);
      run(18);
      wait_p(3);
      DIGIT_DATA = 12'h222; DIGIT_EN = 3'b111; LOAD = 1'b1;
      wait_p(9);
      RST = 1'b1; LOAD = 1'b0;
      a0 = acks_a;
      cycle();
      RST = 1'b0;
      chk("s4_an", an_a, 3'b111);
      chk("s4_cur_digit", cd_a, 0);
      chk("s4_ack", ack_a, 0);
      run(36);
      chk("s4_no_ack", acks_a - a0, 0);
      wait_p(0);
      a0 = acks_a;
      DIGIT_DATA = 12'hB68; DIGIT_EN = 3'b011; LOAD = 1'b1;
      run(54);
      LOAD = 1'b0;
      chk("s5_acks", acks_a - a0, 3);
      for (int i = 0; i < 1500; i++) begin
         cycle();
         if (RST) RST = 1'b0;
         else if ($urandom_range(199) == 0) begin
            RST = 1'b1;
            if ($urandom_range(1) == 0) LOAD = 1'b0;
         end
         if (LOAD && ack_a) LOAD = $urandom_range(3) == 0;
         else if (!LOAD) begin
            if ($urandom_range(2) == 0) begin
               DIGIT_DATA = 12'($urandom);
               DIGIT_EN = 3'($urandom);
            end
            if ($urandom_range(15) == 0) LOAD = 1'b1;
         end
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
